// File: rtl/kamacore_stage_mem_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Request fields are registered by the master; ack is a one-cycle completion strobe.
interface kamacore_stage_mem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/kamacore_stage_mem.sv
// RV32 memory stage: runs loads/stores over the req/ack data bus, fills MEM/WB,
// stalls upstream while an access is outstanding and exposes EX/MEM for forwarding.
module kamacore_stage_mem #(
    parameter int CPU_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exmem_valid,
    input  logic [31:0]          exmem_instruction,
    input  logic [CPU_WIDTH-1:0] exmem_alu_result,
    input  logic [CPU_WIDTH-1:0] exmem_rs2_data,
    input  logic                 exmem_mem_read,
    input  logic                 exmem_mem_write,
    input  logic                 exmem_reg_write,
    output logic                 stall,
    kamacore_stage_mem_if.master dmem,
    output logic                 memwb_valid,
    output logic [CPU_WIDTH-1:0] memwb_result,
    output logic [4:0]           memwb_rd,
    output logic                 memwb_reg_write,
    output logic [1:0]           memwb_fault,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [CPU_WIDTH-1:0] fwd_data
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, BUS} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q, we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic          mv_q, mrw_q;
    logic [31:0]   mres_q;
    logic [4:0]    mrd_q;
    logic [1:0]    mflt_q;

    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a;
    logic        is_mem, ok, rd_wr, timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, shifted, load_d;
    logic        unused_instr_bits;

    assign f3     = exmem_instruction[14:12];
    assign rd     = exmem_instruction[11:7];
    assign a      = exmem_alu_result;
    assign is_mem = exmem_valid & (exmem_mem_read | exmem_mem_write);
    assign rd_wr  = exmem_reg_write & (rd != 5'd0);
    assign unused_instr_bits = ^{exmem_instruction[31:15], exmem_instruction[6:0]};

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        ok = 1'b0;
        if (exmem_mem_read) begin
            case (f3)
                3'b000, 3'b100: ok = 1'b1;
                3'b001, 3'b101: ok = ~a[0];
                3'b010:         ok = (a[1:0] == 2'b00);
                default:        ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000:  ok = 1'b1;
                3'b001:  ok = ~a[0];
                3'b010:  ok = (a[1:0] == 2'b00);
                default: ok = 1'b0;
            endcase
        end
    end

    // Lane steering: byte enables follow the access size, data is replicated across lanes.
    always_comb begin
        be_d    = 4'hF;
        wdata_d = exmem_rs2_data;
        case (f3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << a[1:0];
                wdata_d = {4{exmem_rs2_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << a[1:0];
                wdata_d = {2{exmem_rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = dmem.dmem_rdata >> {a[1:0], 3'b000};

    always_comb begin
        load_d = dmem.dmem_rdata;
        case (f3)
            3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_d = {24'd0, shifted[7:0]};
            3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_d = {16'd0, shifted[15:0]};
            default: load_d = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        if (state_q == IDLE) stall = is_mem & ok;
        else                 stall = ~dmem.dmem_ack & ~timeout_hit;
    end

    // EX/MEM is held while stalled, so its fields stay valid for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            mv_q    <= 1'b0;
            mres_q  <= '0;
            mrd_q   <= '0;
            mrw_q   <= 1'b0;
            mflt_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!exmem_valid) begin
                        mv_q <= 1'b0;
                    end else if (!is_mem) begin
                        mv_q   <= 1'b1;
                        mres_q <= a;
                        mrd_q  <= rd;
                        mrw_q  <= rd_wr;
                        mflt_q <= 2'b00;
                    end else if (!ok) begin
                        mv_q   <= 1'b1;
                        mres_q <= a;
                        mrd_q  <= rd;
                        mrw_q  <= 1'b0;
                        mflt_q <= 2'b01;
                    end else begin
                        mv_q    <= 1'b0;
                        req_q   <= 1'b1;
                        we_q    <= exmem_mem_write;
                        addr_q  <= {a[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        cnt_q   <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (dmem.dmem_ack) begin
                        req_q   <= 1'b0;
                        mv_q    <= 1'b1;
                        mres_q  <= exmem_mem_read ? load_d : 32'd0;
                        mrd_q   <= rd;
                        mrw_q   <= rd_wr & exmem_mem_read;
                        mflt_q  <= 2'b00;
                        state_q <= IDLE;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        mv_q    <= 1'b1;
                        mres_q  <= '0;
                        mrd_q   <= rd;
                        mrw_q   <= 1'b0;
                        mflt_q  <= 2'b10;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign memwb_valid     = mv_q;
    assign memwb_result    = mres_q;
    assign memwb_rd        = mrd_q;
    assign memwb_reg_write = mrw_q;
    assign memwb_fault     = mflt_q;

    assign fwd_valid = exmem_valid & exmem_reg_write & ~exmem_mem_read & (rd != 5'd0);
    assign fwd_rd    = rd;
    assign fwd_data  = exmem_alu_result;
endmodule
